play_controller: RTL and testbench

Playback FSM for the voice record/playback system. On a play-button press it walks the sample memory from address 0 up to the last address written by the record FSM, paced by the sample-rate strobe, and delivers one sample per strobe to the audio output path. It drives `read_address` and `flag_play` into the address controller, which is the memory's read-side counterpart to the record FSM's `write_address`/`flag_record`.

---
 rtl/play_controller.sv | 127 ++++++++++++
 tb/tb_play_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/play_controller.sv
// Playback FSM: walks sample memory 0..end_addr, one sample per sample_tick.
// Ports: clk, resetn (async low); play_btn, flag_record, msg_valid,
// last_address, sample_tick, mem_data in; read_address, flag_play,
// sample_out, sample_valid, play_done out (all registered).
module play_controller #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              play_btn,
  input  logic              flag_record,
  input  logic              msg_valid,
  input  logic [ADDR_W-1:0] last_address,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] read_address,
  output logic              flag_play,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              play_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              btn_q;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sout_q, sout_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              flag_q, flag_d;
  logic              press;
  logic              abort;

  assign press = play_btn & ~btn_q;
  // A fresh press or a starting recording both cancel playback.
  assign abort = flag_record | press;

  always_comb begin
    state_d = state_q;
    end_d   = end_q;
    addr_d  = addr_q;
    sout_d  = sout_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (press && msg_valid && !flag_record) begin
          end_d   = last_address;
          state_d = S_FETCH;
        end
      end
      // One cycle for the synchronous memory read; ticks are dropped.
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (sample_tick) begin
          sout_d  = mem_data;
          valid_d = 1'b1;
          if (addr_q == end_q) begin
            state_d = S_DONE;
            addr_d  = '0;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
    flag_d = (state_d == S_FETCH) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      btn_q   <= 1'b0;
      end_q   <= '0;
      addr_q  <= '0;
      sout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= play_btn;
      end_q   <= end_d;
      addr_q  <= addr_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
    end
  end

  assign read_address = addr_q;
  assign flag_play    = flag_q;
  assign sample_out   = sout_q;
  assign sample_valid = valid_q;
  assign play_done    = done_q;

endmodule

// File: tb/tb_play_controller.sv
// Scoreboard bench for play_controller.
// Expected samples are queued by each test; a monitor pops on sample_valid.
module tb_play_controller;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          play_btn;
  logic          flag_record;
  logic          msg_valid;
  logic [AW-1:0] last_address;
  logic          sample_tick;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] read_address;
  logic          flag_play;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          play_done;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  play_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .resetn(resetn),
    .play_btn(play_btn),
    .flag_record(flag_record),
    .msg_valid(msg_valid),
    .last_address(last_address),
    .sample_tick(sample_tick),
    .mem_data(mem_data),
    .read_address(read_address),
    .flag_play(flag_play),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .play_done(play_done)
  );

  always @(posedge clk) mem_data <= mem[read_address];

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (resetn) begin
      if (sample_valid) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample got %h", sample_out);
        end else begin
          e = exp_q.pop_front();
          if (sample_out !== e) begin
            errors++;
            $display("FAIL sample got %h exp %h", sample_out, e);
          end
        end
      end
      if (play_done) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) play_btn = 1'b1;
    @(negedge clk) play_btn = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      play_btn     = 1'($urandom);
      flag_record  = 1'($urandom);
      msg_valid    = 1'($urandom);
      last_address = AW'($urandom);
      sample_tick  = 1'($urandom);
    end
    @(negedge clk);
    play_btn = 0; flag_record = 0; msg_valid = 0;
    sample_tick = 0; last_address = '0;
    resetn = 1'b1;
    cyc(2);
    chk("reset_outs", int'({read_address, flag_play, sample_out,
        sample_valid, play_done}), 0);
    msg_valid = 1'b1;
    last_address = 10'd5;
    exp_q.push_back(mem[0]);
    press();
    cyc(3);
    tick();
    cyc(3);
    chk("pre_reset_flag", int'(flag_play), 1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_outs", int'({read_address, flag_play, sample_out,
        sample_valid, play_done}), 0);
    @(negedge clk) resetn = 1'b1;
    chk("reset_queue", exp_q.size(), 0);
    exp_q.delete();
    cyc(2);
  endtask

  task automatic test_normal();
    int v0, d0;
    mem[0] = 8'h11; mem[1] = 8'h22;
    mem[2] = 8'h33; mem[3] = 8'h44;
    v0 = valid_cnt; d0 = done_cnt;
    msg_valid = 1'b1;
    last_address = 10'd3;
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
    press();
    chk("press_flag", int'(flag_play), 1);
    chk("press_addr", int'(read_address), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(9);
      chk("normal_addr", int'(read_address), i);
      tick();
    end
    cyc(1);
    chk("normal_valids", valid_cnt - v0, 4);
    chk("normal_done", done_cnt - d0, 1);
    chk("normal_end_flag", int'(flag_play), 0);
    chk("normal_end_addr", int'(read_address), 0);
    chk("normal_hold", int'(sample_out), 8'h44);
    chk("normal_queue", exp_q.size(), 0);
  endtask

  task automatic test_gating();
    int v0 = valid_cnt;
    int fl = 0;
    msg_valid = 1'b0;
    press();
    for (int i = 0; i < 6; i++) begin
      fl |= int'(flag_play);
      tick();
    end
    msg_valid = 1'b1;
    flag_record = 1'b1;
    press();
    for (int i = 0; i < 6; i++) begin
      fl |= int'(flag_play);
      tick();
    end
    flag_record = 1'b0;
    chk("gate_flag", fl, 0);
    chk("gate_valids", valid_cnt - v0, 0);
  endtask

  task automatic test_abort(input bit use_rec);
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt;
    msg_valid = 1'b1;
    last_address = 10'd5;
    exp_q.push_back(mem[0]);
    exp_q.push_back(mem[1]);
    press();
    cyc(2);
    tick();
    cyc(2);
    tick();
    cyc(3);
    @(negedge clk);
    sample_tick = 1'b1;
    if (use_rec) flag_record = 1'b1;
    else play_btn = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    flag_record = 1'b0;
    play_btn = 1'b0;
    chk(use_rec ? "abort_rec_flag" : "abort_btn_flag", int'(flag_play), 0);
    cyc(4);
    chk(use_rec ? "abort_rec_valids" : "abort_btn_valids",
        valid_cnt - v0, 2);
    chk(use_rec ? "abort_rec_done" : "abort_btn_done", done_cnt - d0, 0);
    chk("abort_queue", exp_q.size(), 0);
  endtask

  task automatic test_single();
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt;
    last_address = 10'd0;
    exp_q.push_back(mem[0]);
    press();
    cyc(2);
    tick();
    cyc(1);
    chk("single_valids", valid_cnt - v0, 1);
    chk("single_done", done_cnt - d0, 1);
    chk("single_flag", int'(flag_play), 0);
  endtask

  task automatic test_full();
    int v0, d0, bad;
    v0 = valid_cnt; d0 = done_cnt; bad = 0;
    last_address = 10'd1023;
    for (int i = 0; i < 1024; i++) exp_q.push_back(mem[i]);
    @(negedge clk) play_btn = 1'b1;
    @(negedge clk);
    last_address = 10'd2;
    for (int i = 0; i < 1024; i++) begin
      if (read_address !== AW'(i) || flag_play !== 1'b1) bad++;
      tick();
    end
    cyc(1);
    play_btn = 1'b0;
    chk("full_addr_steps", bad, 0);
    chk("full_valids", valid_cnt - v0, 1024);
    chk("full_done", done_cnt - d0, 1);
    chk("full_end_addr", int'(read_address), 0);
    chk("full_end_flag", int'(flag_play), 0);
    chk("full_queue", exp_q.size(), 0);
  endtask

  task automatic test_tick_spacing();
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt;
    last_address = 10'd2;
    for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
    press();
    cyc(2);
    @(negedge clk) sample_tick = 1'b1;
    cyc(2);
    sample_tick = 1'b0;
    cyc(1);
    chk("space_one_valid", valid_cnt - v0, 1);
    chk("space_addr", int'(read_address), 1);
    tick();
    tick();
    cyc(1);
    chk("space_valids", valid_cnt - v0, 3);
    chk("space_done", done_cnt - d0, 1);
    chk("space_queue", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'((i * 37 + 5) ^ (i >> 3));
    resetn = 0; play_btn = 0; flag_record = 0; msg_valid = 0;
    last_address = '0; sample_tick = 0;
    test_reset();
    test_normal();
    test_gating();
    test_abort(1'b1);
    test_abort(1'b0);
    test_single();
    test_full();
    test_tick_spacing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
